// File: rtl/kyogenrv_avm_pkg.sv
// -----------------------------------------------------------------------------
// kyogenrv_avm_pkg
// Shared definitions for the KyogenRV Avalon-MM data-memory responder:
//   - state_t       : responder FSM states (IDLE, BUSY, DONE)
//   - LAT_W         : width of the wait-state latency counter
//   - ERR_*         : one-hot error-cause codes, also carried on the
//                     responder's internal debug bus
//   - f_err_cause() : builds the error cause for a transfer entering DONE
// -----------------------------------------------------------------------------
package kyogenrv_avm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LAT_W = 4;

   localparam logic [2:0] ERR_NONE  = 3'b000;
   localparam logic [2:0] ERR_RANGE = 3'b001;  // address outside the RAM window
   localparam logic [2:0] ERR_BOTH  = 3'b010;  // read and write requested together
   localparam logic [2:0] ERR_ABORT = 3'b100;  // request withdrawn while waiting

   // Cause reported for a transfer that completes in DONE.
   function automatic logic [2:0] f_err_cause(input logic in_range, input logic both);
      logic [2:0] v;
      v = ERR_NONE;
      if (!in_range) v = v | ERR_RANGE;
      if (both)      v = v | ERR_BOTH;
      return v;
   endfunction

endpackage

// File: rtl/kyogenrv_avm_bram.sv
// -----------------------------------------------------------------------------
// kyogenrv_avm_bram
// Single-port synchronous RAM, 32-bit words, four byte-write enables and a
// registered read port. The read register only updates when i_re is high, so
// o_rdata holds the last word read. Drop-in shape for a vendor altsyncram.
// Ports:
//   i_clk    : clock, rising edge
//   i_addr   : word address
//   i_wdata  : write data
//   i_be     : byte-lane enables for writes (bit n -> bits [8n+7:8n])
//   i_we     : write strobe
//   i_re     : read strobe (loads o_rdata on the same edge)
//   o_rdata  : registered read data
// -----------------------------------------------------------------------------
module kyogenrv_avm_bram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic [3:0]    i_be,
   input  logic          i_we,
   input  logic          i_re,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int n = 0; n < 4; n++) begin
            if (i_be[n]) r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/kyogenrv_avm_dmem_responder.sv
// -----------------------------------------------------------------------------
// kyogenrv_avm_dmem_responder
// Avalon-MM responder for the KyogenRV data-memory port. A request is held
// off with dmem_waitrequest for a programmable number of cycles, then
// completes against an internal byte-enabled RAM. Range and protocol errors
// produce a one-cycle err_pulse.
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   r_dmem_data_req          : read request (held until accepted)
//   w_dmem_data_req          : write request (held until accepted)
//   dmem_addr                : byte address, bits [1:0] ignored
//   w_dmem_data              : write data
//   w_dmem_data_byteenable   : write byte lanes
//   dmem_waitrequest         : high while a present request is not accepted
//   r_dmem_data_ack          : one-cycle read-data-valid strobe
//   r_dmem_data              : read data, qualified by r_dmem_data_ack
//   busy                     : FSM not in IDLE
//   err_pulse                : one-cycle error strobe
// -----------------------------------------------------------------------------
module kyogenrv_avm_dmem_responder
   import kyogenrv_avm_pkg::*;
#(
   parameter int          DEPTH_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          READ_LATENCY  = 1,
   parameter int          WRITE_LATENCY = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        r_dmem_data_req,
   input  logic        w_dmem_data_req,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] w_dmem_data,
   input  logic [3:0]  w_dmem_data_byteenable,
   output logic        dmem_waitrequest,
   output logic        r_dmem_data_ack,
   output logic [31:0] r_dmem_data,
   output logic        busy,
   output logic        err_pulse
);

   localparam int                AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0]       SPAN   = 33'(DEPTH_WORDS) << 2;
   localparam logic [LAT_W-1:0]  RD_LAT = LAT_W'(READ_LATENCY);
   localparam logic [LAT_W-1:0]  WR_LAT = LAT_W'(WRITE_LATENCY);

   state_t           r_state;
   logic [LAT_W-1:0] r_cnt;
   logic [AW-1:0]    r_idx;
   logic [31:0]      r_wdata;
   logic [3:0]       r_be;
   logic             r_is_wr;
   logic             r_in_range;
   logic             r_both;
   logic             r_ack;
   logic             r_zero;       // read result forced to zero (reset / out of range)
   logic [2:0]       r_err_cause;  // debug bus; any set bit is the error strobe

   logic             w_req_any;
   logic [31:0]      w_diff;
   logic             w_in_range_bus;
   logic             w_both_bus;
   logic [LAT_W-1:0] w_lat_bus;
   logic             w_idle_go;
   logic             w_enter_done;
   logic             w_entry_is_wr;
   logic             w_entry_in_range;
   logic [AW-1:0]    w_ram_addr;
   logic             w_ram_we;
   logic             w_ram_re;
   logic [31:0]      w_ram_q;

   assign w_req_any      = r_dmem_data_req | w_dmem_data_req;
   assign w_diff         = dmem_addr - BASE_ADDR;
   // diff < DEPTH*4 is the same test as (diff >> 2) < DEPTH
   assign w_in_range_bus = (dmem_addr >= BASE_ADDR) && ({1'b0, w_diff} < SPAN);
   assign w_both_bus     = r_dmem_data_req & w_dmem_data_req;
   assign w_lat_bus      = w_dmem_data_req ? WR_LAT : RD_LAT;

   assign w_idle_go      = (r_state == IDLE) && w_req_any;
   assign w_enter_done   = (w_idle_go && (w_lat_bus == '0)) ||
                           ((r_state == BUSY) && w_req_any && (r_cnt <= LAT_W'(1)));

   // In IDLE the transfer is not captured yet, so zero-latency accesses use
   // the live bus; afterwards the frozen copies drive the RAM.
   assign w_entry_is_wr    = (r_state == IDLE) ? w_dmem_data_req : r_is_wr;
   assign w_entry_in_range = (r_state == IDLE) ? w_in_range_bus  : r_in_range;
   assign w_ram_addr       = (r_state == IDLE) ? w_diff[AW+1:2]  : r_idx;

   // The RAM read register loads on the edge into DONE so data is valid with ack.
   assign w_ram_re = w_enter_done && !w_entry_is_wr && w_entry_in_range;
   assign w_ram_we = (r_state == DONE) && r_is_wr && r_in_range && !reset;

   kyogenrv_avm_bram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_bram (
      .i_clk   (clock),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .i_be    (r_be),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .o_rdata (w_ram_q)
   );

   // Transfer capture: address, data and type are frozen for the whole access.
   always_ff @(posedge clock) begin
      if (w_idle_go) begin
         r_idx      <= w_diff[AW+1:2];
         r_wdata    <= w_dmem_data;
         r_be       <= w_dmem_data_byteenable;
         r_is_wr    <= w_dmem_data_req;
         r_in_range <= w_in_range_bus;
         r_both     <= w_both_bus;
      end
   end

   // Responder FSM with registered ack / error outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ack       <= 1'b0;
         r_zero      <= 1'b1;
         r_err_cause <= ERR_NONE;
      end else begin
         r_ack       <= 1'b0;
         r_err_cause <= ERR_NONE;
         case (r_state)
            IDLE: begin
               if (w_req_any) begin
                  r_cnt <= w_lat_bus;
                  if (w_lat_bus == '0) begin
                     r_state     <= DONE;
                     r_ack       <= !w_dmem_data_req;
                     r_err_cause <= f_err_cause(w_in_range_bus, w_both_bus);
                     if (!w_dmem_data_req) r_zero <= !w_in_range_bus;
                  end else begin
                     r_state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!w_req_any) begin
                  r_state     <= IDLE;
                  r_cnt       <= '0;
                  r_err_cause <= ERR_ABORT;
               end else if (r_cnt <= LAT_W'(1)) begin
                  r_state     <= DONE;
                  r_cnt       <= '0;
                  r_ack       <= !r_is_wr;
                  r_err_cause <= f_err_cause(r_in_range, r_both);
                  if (!r_is_wr) r_zero <= !r_in_range;
               end else begin
                  r_cnt <= r_cnt - LAT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign dmem_waitrequest = w_req_any && (r_state != DONE);
   assign r_dmem_data_ack  = r_ack;
   assign r_dmem_data      = r_zero ? 32'h0000_0000 : w_ram_q;
   assign busy             = (r_state != IDLE);
   assign err_pulse        = |r_err_cause;

endmodule

// File: tb/tb_kyogenrv_avm_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_kyogenrv_avm_dmem_responder
// Directed bench for the dmem responder. Instance A uses read latency 1 and
// write latency 0; instance B uses read latency 3 and write latency 2 so that
// reads and writes both spend time in BUSY. Expected read data comes from a
// byte-masked memory model and is queued when the read is issued.
// -----------------------------------------------------------------------------
module tb_kyogenrv_avm_dmem_responder;

   localparam int DEPTH  = 1024;
   localparam int A_RLAT = 1;
   localparam int A_WLAT = 0;
   localparam int B_RLAT = 3;
   localparam int B_WLAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be    = '0;
   logic        a_rreq = 1'b0, a_wreq = 1'b0, b_rreq = 1'b0, b_wreq = 1'b0;

   logic        a_wait, a_ack, a_busy, a_err;
   logic [31:0] a_rdata;
   logic        b_wait, b_ack, b_busy, b_err;
   logic [31:0] b_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mdl_a [int];
   logic [31:0] mdl_b [int];

   typedef struct packed {
      logic        w;
      logic        a;
      logic        bz;
      logic        e;
      logic [31:0] d;
   } obs_t;

   always #5 clock = ~clock;

   kyogenrv_avm_dmem_responder #(
      .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LATENCY(A_RLAT), .WRITE_LATENCY(A_WLAT)
   ) u_dut_a (
      .clock(clock), .reset(reset),
      .r_dmem_data_req(a_rreq), .w_dmem_data_req(a_wreq),
      .dmem_addr(addr), .w_dmem_data(wdata), .w_dmem_data_byteenable(be),
      .dmem_waitrequest(a_wait), .r_dmem_data_ack(a_ack), .r_dmem_data(a_rdata),
      .busy(a_busy), .err_pulse(a_err)
   );

   kyogenrv_avm_dmem_responder #(
      .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LATENCY(B_RLAT), .WRITE_LATENCY(B_WLAT)
   ) u_dut_b (
      .clock(clock), .reset(reset),
      .r_dmem_data_req(b_rreq), .w_dmem_data_req(b_wreq),
      .dmem_addr(addr), .w_dmem_data(wdata), .w_dmem_data_byteenable(be),
      .dmem_waitrequest(b_wait), .r_dmem_data_ack(b_ack), .r_dmem_data(b_rdata),
      .busy(b_busy), .err_pulse(b_err)
   );

   function automatic obs_t get(input bit b);
      obs_t o;
      if (b) o = '{w: b_wait, a: b_ack, bz: b_busy, e: b_err, d: b_rdata};
      else   o = '{w: a_wait, a: a_ack, bz: a_busy, e: a_err, d: a_rdata};
      return o;
   endfunction

   function automatic logic [31:0] model_get(input bit b, input int idx);
      if (b) return mdl_b.exists(idx) ? mdl_b[idx] : 32'h0;
      return mdl_a.exists(idx) ? mdl_a[idx] : 32'h0;
   endfunction

   task automatic model_wr(input bit b, input int idx, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] cur;
      cur = model_get(b, idx);
      for (int n = 0; n < 4; n++) if (m[n]) cur[8*n +: 8] = d[8*n +: 8];
      if (b) mdl_b[idx] = cur;
      else   mdl_a[idx] = cur;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit b, input bit rd, input bit wr);
      if (b) begin b_rreq = rd; b_wreq = wr; end
      else   begin a_rreq = rd; a_wreq = wr; end
   endtask

   // One complete handshake: drive, count waitrequest cycles, check the
   // DONE cycle, release, and check the following IDLE cycle.
   task automatic xfer(input bit b, input bit rd, input bit wr, input logic [31:0] ad,
                       input logic [31:0] d, input logic [3:0] m, input string tag);
      obs_t        o;
      int          waits;
      int          lat;
      bit          oor;
      int          idx;
      logic [31:0] want;
      lat = b ? (wr ? B_WLAT : B_RLAT) : (wr ? A_WLAT : A_RLAT);
      oor = (ad >= 32'(DEPTH * 4));
      idx = int'(ad[31:2]);
      if (rd && !wr) exp_q.push_back(oor ? 32'h0 : model_get(b, idx));
      @(negedge clock);
      addr = ad; wdata = d; be = m;
      set_req(b, rd, wr);
      #1;
      waits = 0;
      o = get(b);
      while (o.w === 1'b1 && waits < 50) begin
         waits++;
         @(negedge clock);
         o = get(b);
      end
      chk({tag, ".wait_cycles"}, waits, 1 + lat);
      chk({tag, ".ack"},  {31'b0, o.a},  {31'b0, rd && !wr});
      chk({tag, ".err"},  {31'b0, o.e},  {31'b0, oor || (rd && wr)});
      chk({tag, ".busy"}, {31'b0, o.bz}, 32'd1);
      if (o.a === 1'b1 || (rd && !wr)) begin
         want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
         if (o.a === 1'b1) chk({tag, ".rdata"}, o.d, want);
      end
      if (wr && !oor) model_wr(b, idx, d, m);
      set_req(b, 1'b0, 1'b0);
      @(negedge clock);
      o = get(b);
      chk({tag, ".idle_busy"}, {31'b0, o.bz}, 32'd0);
      chk({tag, ".idle_ack"},  {31'b0, o.a},  32'd0);
      chk({tag, ".idle_err"},  {31'b0, o.e},  32'd0);
   endtask

   initial begin
      obs_t o;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      for (int b = 0; b < 2; b++) begin
         o = get(b[0]);
         chk("rst.wait",  {31'b0, o.w},  32'd0);
         chk("rst.ack",   {31'b0, o.a},  32'd0);
         chk("rst.rdata", o.d,           32'd0);
         chk("rst.err",   {31'b0, o.e},  32'd0);
         chk("rst.busy",  {31'b0, o.bz}, 32'd0);
      end

      // Basic write/read, then a partial byte-lane update
      xfer(0, 0, 1, 32'h10, 32'hCAFE_BABE, 4'hF, "a_wr10");
      xfer(0, 1, 0, 32'h10, 32'h0,         4'hF, "a_rd10");
      xfer(0, 0, 1, 32'h10, 32'h1122_3344, 4'b0101, "a_wr10_be5");
      xfer(0, 1, 0, 32'h10, 32'h0,         4'hF, "a_rd10_merged");

      // Out-of-range read and write; word 0 must not be aliased
      xfer(0, 0, 1, 32'h0,    32'h1357_9BDF, 4'hF, "a_wr0");
      xfer(0, 1, 0, 32'h1000, 32'h0,         4'hF, "a_rd_oor");
      xfer(0, 0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, "a_wr_oor");
      xfer(0, 1, 0, 32'h0,    32'h0,         4'hF, "a_rd0");
      xfer(0, 1, 0, 32'hFFC,  32'h0,         4'hF, "a_rd_last");

      // Simultaneous read and write behaves as a flagged write
      xfer(0, 1, 1, 32'h20, 32'h5A5A_5A5A, 4'hF, "a_both");
      xfer(0, 1, 0, 32'h20, 32'h0,         4'hF, "a_rd20");
      xfer(0, 0, 1, 32'h20, 32'h0000_0000, 4'h0, "a_wr_be0");
      xfer(0, 1, 0, 32'h20, 32'h0,         4'hF, "a_rd20_after_be0");

      // Longer latencies
      xfer(1, 0, 1, 32'h40, 32'h0102_0304, 4'hF, "b_wr40");
      xfer(1, 1, 0, 32'h40, 32'h0,         4'hF, "b_rd40");

      // Read withdrawn during BUSY: abort with error, no ack
      @(negedge clock);
      addr = 32'h40; b_rreq = 1'b1;
      #1;
      chk("abort.wait", {31'b0, b_wait}, 32'd1);
      @(negedge clock);
      chk("abort.busy_in_wait", {31'b0, b_busy}, 32'd1);
      b_rreq = 1'b0;
      @(negedge clock);
      chk("abort.ack",  {31'b0, b_ack},  32'd0);
      chk("abort.err",  {31'b0, b_err},  32'd1);
      chk("abort.busy", {31'b0, b_busy}, 32'd0);
      @(negedge clock);
      chk("abort.err_cleared", {31'b0, b_err}, 32'd0);

      // Reset during BUSY of a write: write discarded
      @(negedge clock);
      addr = 32'h40; wdata = 32'hFFFF_FFFF; be = 4'hF; b_wreq = 1'b1;
      @(negedge clock);
      chk("rstmid.busy_before", {31'b0, b_busy}, 32'd1);
      reset = 1'b1; b_wreq = 1'b0;
      @(negedge clock);
      chk("rstmid.busy", {31'b0, b_busy}, 32'd0);
      chk("rstmid.ack",  {31'b0, b_ack},  32'd0);
      reset = 1'b0;
      xfer(1, 1, 0, 32'h40, 32'h0, 4'hF, "b_rd40_after_rst");

      // Instance A memory survives the shared reset
      xfer(0, 1, 0, 32'h20, 32'h0, 4'hF, "a_rd20_after_rst");

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kyogenrv_avm_dmem_responder.md
Name: kyogenrv_avm_dmem_responder

Overview:
Avalon-MM responder (slave) for the data memory port of the KyogenRV FPGA top. It is the memory-side counterpart of the CPU's dmem initiator. It accepts read and write requests, holds dmem_waitrequest high for a programmable latency, then completes the transfer against an internal word-addressed RAM with byte enables. It also flags protocol and address-range errors for debug.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in internal RAM (power of two)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
READ_LATENCY, 1, extra wait cycles for a read (0..15)
WRITE_LATENCY, 0, extra wait cycles for a write (0..15)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
r_dmem_data_req  in  1  read request, held by initiator until accepted
w_dmem_data_req  in  1  write request, held by initiator until accepted
dmem_addr  in  32  byte address; bits [1:0] ignored
w_dmem_data  in  32  write data
w_dmem_data_byteenable  in  4  write byte lanes; bit n enables bits [8n+7:8n]
dmem_waitrequest  out  1  high = request not yet accepted
r_dmem_data_ack  out  1  one-cycle read-data-valid strobe
r_dmem_data  out  32  read data, valid only while ack is high
busy  out  1  FSM not in IDLE
err_pulse  out  1  one-cycle error strobe

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values: state=IDLE, r_dmem_data_ack=0, r_dmem_data=0, err_pulse=0, busy=0, latency counter=0. RAM contents are not reset.
- Address decode: idx=(dmem_addr-BASE_ADDR)>>2. The address is in range iff dmem_addr>=BASE_ADDR and idx<DEPTH_WORDS.
- Request: req_any = r_dmem_data_req | w_dmem_data_req.
- dmem_waitrequest is combinational: req_any & (state!=DONE). It is 0 when no request is present.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on req_any at cycle t:
  - capture addr, wdata, byteenable and type (write wins if both reqs high);
  - load counter with READ_LATENCY or WRITE_LATENCY;
  - go to BUSY if counter>0, else DONE.
- BUSY: decrement counter each cycle; go to DONE when it reaches 1.
- DONE (cycle t+1+LATENCY): waitrequest=0, so the transfer is accepted this cycle.
  - Read: r_dmem_data_ack=1 and r_dmem_data=RAM[idx] (registered on entry to DONE).
  - Write: masked byte write into RAM[idx] on the DONE clock edge.
  - Next state is IDLE. Back-to-back requests therefore see a minimum 2-cycle spacing.
- Out-of-range access: a read returns 32'h0000_0000 with ack; a write is dropped. Both raise err_pulse for 1 cycle in DONE.
- Simultaneous r and w requests: treated as a write, with err_pulse in DONE.
- Request withdrawn while in BUSY (protocol violation): abort to IDLE, no RAM write, no ack, err_pulse for 1 cycle.
- Captured address, data and type are frozen during BUSY; changes on the bus are ignored.
- Byteenable 4'b0000 on a write: the transfer completes normally with no RAM change and no error.
- Reset mid-operation: return to IDLE next cycle; the pending write is discarded and ack is deasserted.
- r_dmem_data holds its last value after ack falls; consumers must use ack.

Decomposition:
- Shared package kyogenrv_avm_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - localparam LAT_W=4;
  - the error-cause constants ERR_RANGE, ERR_BOTH, ERR_ABORT (also exposed on an internal debug bus).
- Sub-module kyogenrv_avm_bram: single-port synchronous RAM with 4 byte-write enables, registered read, DEPTH_WORDS parameter, so it can be swapped for a vendor altsyncram.

Test Plan:
- Reset, then write 0xCAFEBABE to 0x10 with BE=4'hF (WRITE_LATENCY=0) -> waitrequest high for 1 cycle then low; busy=1 for 1 cycle; no err.
- Read 0x10 with READ_LATENCY=1 -> waitrequest high for 2 cycles; in the 3rd cycle waitrequest=0, ack=1, r_dmem_data=0xCAFEBABE.
- Write 0x11223344 to 0x10 with BE=4'b0101, then read -> 0xCA22BA44.
- Read 0x1000 with DEPTH_WORDS=1024 -> ack with data 0x00000000 and err_pulse=1; a write to 0x1000 leaves RAM unchanged and pulses err.
- Assert r_dmem_data_req and w_dmem_data_req together (addr 0x20, data 0x5A5A5A5A, BE=F) -> write performed, err_pulse=1, no ack; a subsequent read returns 0x5A5A5A5A.
- Start a read with READ_LATENCY=3 and drop req after 1 cycle -> no ack, err_pulse=1, IDLE. Separately, assert reset during BUSY of a write -> ack=0, busy=0 next cycle, and a later read shows the old data.
